// File: rtl/ddr_pkg.sv
// Shared types, field widths and default timing for the two-port DDR command arbiter.
package ddr_pkg;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned BA_W  = 2;
  localparam int unsigned ROW_W = 13;
  localparam int unsigned COL_W = 10;
  localparam int unsigned LEN_W = 4;

  localparam int unsigned REFRESH_INTERVAL_DEF = 780;
  localparam int unsigned ISSUE_TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_REFRESH   = 2'd3
  } state_e;

  // Command fields latched at grant time and held through the transaction
  typedef struct packed {
    logic             wr;
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [LEN_W-1:0] len;
  } cmd_t;

endpackage

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh countdown with a sticky pending flag and overrun detection.
module ddr_refresh_timer
  import ddr_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic pend_o,
  output logic overrun_c_o
);

  localparam int unsigned CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             expire;

  // An expiry that lands on the acknowledge cycle re-arms pending rather than being lost
  always_comb begin
    expire = (cnt_q == '0);
    cnt_d  = expire ? RELOAD : cnt_q - CNT_W'(1);
    pend_d = pend_q;
    if (clr_i)  pend_d = 1'b0;
    if (expire) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= RELOAD;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o      = pend_q;
  assign overrun_c_o = expire & pend_q & ~clr_i;

endmodule

// File: rtl/ddr_arbiter.sv
// Round-robin arbiter for two requesters sharing one SDRAM driver, with periodic
// refresh insertion and an issue-stage timeout.
module ddr_arbiter
  import ddr_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int unsigned ISSUE_TIMEOUT    = ISSUE_TIMEOUT_DEF
) (
  input  logic                  SYS_CLK_100M,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ-1:0]       REQ_WR,
  input  logic [NREQ*BA_W-1:0]  REQ_BA,
  input  logic [NREQ*ROW_W-1:0] REQ_ROW,
  input  logic [NREQ*COL_W-1:0] REQ_COL,
  input  logic [NREQ*LEN_W-1:0] REQ_LEN,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic                  WRITE,
  output logic                  READ,
  output logic [BA_W-1:0]       BA_OUT,
  output logic [ROW_W-1:0]      ADDR_ROW_OUT,
  output logic [COL_W-1:0]      ADDR_COL_OUT,
  output logic [LEN_W-1:0]      WRITE_LENGTH,
  input  logic                  BUSY,
  output logic                  REFRESH_REQ,
  input  logic                  REFRESH_ACK,
  output logic                  ERROR
);

  localparam int unsigned TMO_W = $clog2(ISSUE_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ISSUE_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  cmd_t            cmd_q, cmd_d, sel_cmd;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            write_q, write_d, read_q, read_d;
  logic            rreq_q, rreq_d, err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic            pick, any_req, tmo_hit;
  logic            pend, overrun_c, refresh_clr_c;

  ddr_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh (
    .clk_i       (SYS_CLK_100M),
    .rst_i       (RESET),
    .clr_i       (refresh_clr_c),
    .pend_o      (pend),
    .overrun_c_o (overrun_c)
  );

  // Winner selection and its field slice; last_q also identifies the current owner
  always_comb begin
    any_req     = |REQ;
    pick        = (&REQ) ? ~last_q : REQ[1];
    sel_cmd.wr  = REQ_WR[pick];
    sel_cmd.ba  = pick ? REQ_BA[BA_W +: BA_W]    : REQ_BA[0 +: BA_W];
    sel_cmd.row = pick ? REQ_ROW[ROW_W +: ROW_W] : REQ_ROW[0 +: ROW_W];
    sel_cmd.col = pick ? REQ_COL[COL_W +: COL_W] : REQ_COL[0 +: COL_W];
    sel_cmd.len = '0;
    if (REQ_WR[pick]) sel_cmd.len = pick ? REQ_LEN[LEN_W +: LEN_W] : REQ_LEN[0 +: LEN_W];
    tmo_hit     = ~BUSY && (tmo_q == TMO_LAST);
  end

  always_ff @(posedge SYS_CLK_100M or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pend)                  state_d = ST_REFRESH;
        else if (any_req && !BUSY) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (BUSY)         state_d = ST_WAIT_DONE;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: if (!BUSY)      state_d = ST_IDLE;
      ST_REFRESH:   if (REFRESH_ACK) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Strobes are recomputed every cycle so they fall on the same edge the state leaves ISSUE
  always_comb begin
    gnt_d         = '0;
    done_d        = '0;
    write_d       = 1'b0;
    read_d        = 1'b0;
    rreq_d        = 1'b0;
    err_d         = err_q | overrun_c;
    tmo_d         = '0;
    last_d        = last_q;
    cmd_d         = cmd_q;
    refresh_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend) begin
          rreq_d = 1'b1;
        end else if (any_req && !BUSY) begin
          gnt_d   = pick ? 2'b10 : 2'b01;
          last_d  = pick;
          cmd_d   = sel_cmd;
          write_d = sel_cmd.wr;
          read_d  = ~sel_cmd.wr;
        end
      end
      ST_ISSUE: begin
        if (tmo_hit) begin
          err_d = 1'b1;
        end else if (!BUSY) begin
          tmo_d   = tmo_q + TMO_W'(1);
          write_d = cmd_q.wr;
          read_d  = ~cmd_q.wr;
        end
      end
      ST_WAIT_DONE: if (!BUSY) done_d = last_q ? 2'b10 : 2'b01;
      ST_REFRESH: begin
        if (REFRESH_ACK) refresh_clr_c = 1'b1;
        else             rreq_d        = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYS_CLK_100M or posedge RESET) begin
    if (RESET) begin
      last_q  <= 1'b1;
      cmd_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      rreq_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      write_q <= write_d;
      read_q  <= read_d;
      rreq_q  <= rreq_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign GNT          = gnt_q;
  assign DONE         = done_q;
  assign WRITE        = write_q;
  assign READ         = read_q;
  assign BA_OUT       = cmd_q.ba;
  assign ADDR_ROW_OUT = cmd_q.row;
  assign ADDR_COL_OUT = cmd_q.col;
  assign WRITE_LENGTH = cmd_q.len;
  assign REFRESH_REQ  = rreq_q;
  assign ERROR        = err_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Randomized and directed checks of ddr_arbiter against a transaction-level model.
module tb_ddr_arbiter;

  localparam int OVR_INT = 16;

  logic        clk;
  logic        rst;
  logic [1:0]  req, req_wr;
  logic [3:0]  req_ba;
  logic [25:0] req_row;
  logic [19:0] req_col;
  logic [7:0]  req_len;
  logic        busy, rack;
  logic [1:0]  gnt, done;
  logic        wr_o, rd_o, rreq, err;
  logic [1:0]  ba_o;
  logic [12:0] row_o;
  logic [9:0]  col_o;
  logic [3:0]  len_o;

  logic [1:0]  o_gnt, o_done;
  logic        o_wr, o_rd, o_rreq, o_err;
  logic [1:0]  o_ba;
  logic [12:0] o_row;
  logic [9:0]  o_col;
  logic [3:0]  o_len;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_m   = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ddr_arbiter u_dut (
    .SYS_CLK_100M (clk),     .RESET        (rst),
    .REQ          (req),     .REQ_WR       (req_wr),
    .REQ_BA       (req_ba),  .REQ_ROW      (req_row),
    .REQ_COL      (req_col), .REQ_LEN      (req_len),
    .GNT          (gnt),     .DONE         (done),
    .WRITE        (wr_o),    .READ         (rd_o),
    .BA_OUT       (ba_o),    .ADDR_ROW_OUT (row_o),
    .ADDR_COL_OUT (col_o),   .WRITE_LENGTH (len_o),
    .BUSY         (busy),    .REFRESH_REQ  (rreq),
    .REFRESH_ACK  (rack),    .ERROR        (err)
  );

  ddr_arbiter #(.REFRESH_INTERVAL(OVR_INT)) u_ovr (
    .SYS_CLK_100M (clk),     .RESET        (rst),
    .REQ          (2'b00),   .REQ_WR       (2'b00),
    .REQ_BA       (4'h0),    .REQ_ROW      (26'h0),
    .REQ_COL      (20'h0),   .REQ_LEN      (8'h0),
    .GNT          (o_gnt),   .DONE         (o_done),
    .WRITE        (o_wr),    .READ         (o_rd),
    .BA_OUT       (o_ba),    .ADDR_ROW_OUT (o_row),
    .ADDR_COL_OUT (o_col),   .WRITE_LENGTH (o_len),
    .BUSY         (1'b0),    .REFRESH_REQ  (o_rreq),
    .REFRESH_ACK  (1'b0),    .ERROR        (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic scramble_inputs();
    req     = 2'($urandom);
    req_wr  = 2'($urandom);
    req_ba  = 4'($urandom);
    req_row = 26'($urandom);
    req_col = 20'($urandom);
    req_len = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; busy = 1'b0; rack = 1'b0;
    req = '0; req_wr = '0; req_ba = '0; req_row = '0; req_col = '0; req_len = '0;
    @(posedge clk); #1;
    chk("rst_ctrl", 32'({gnt, done, wr_o, rd_o, rreq, err}), 32'd0);
    chk("rst_fields", 32'({ba_o, row_o, col_o, len_o}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0; last_m = 1;
  endtask

  // One full transaction: request already on the inputs, DUT idle with no refresh pending.
  // d = cycles the strobe stays up before BUSY is seen, blen = cycles BUSY stays high.
  task automatic do_txn(input int d, input int blen, input bit drop_req, input bit scramble);
    int g;
    logic ew;
    logic [1:0] eg, eb;
    logic [12:0] er;
    logic [9:0] ec;
    logic [3:0] el;
    g = (req == 2'b11) ? 1 - last_m : (req[0] ? 0 : 1);
    last_m = g;
    eg = (g == 0) ? 2'b01 : 2'b10;
    ew = req_wr[g];
    eb = req_ba[g*2 +: 2];
    er = req_row[g*13 +: 13];
    ec = req_col[g*10 +: 10];
    el = ew ? req_len[g*4 +: 4] : 4'd0;
    for (int i = 0; i < d; i++) begin
      tick();
      chk("gnt", 32'(gnt), (i == 0) ? 32'(eg) : 32'd0);
      chk("strobe", 32'({wr_o, rd_o}), 32'({ew, ~ew}));
      chk("fields", 32'({ba_o, row_o, col_o, len_o}), 32'({eb, er, ec, el}));
      chk("done_issue", 32'(done), 32'd0);
      if (i == 0 && drop_req) req = 2'b00;
      if (scramble) scramble_inputs();
    end
    busy = 1'b1;
    for (int i = 0; i < blen; i++) begin
      tick();
      chk("strobe_off", 32'({wr_o, rd_o, gnt}), 32'd0);
      chk("done_early", 32'(done), 32'd0);
      if (scramble) scramble_inputs();
    end
    busy = 1'b0;
    tick();
    chk("done", 32'(done), 32'(eg));
  endtask

  initial begin
    int hold;

    // Reset values, then refresh overrun on the short-interval instance
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("ovr_rreq", 32'(o_rreq), 32'(cyc >= OVR_INT + 1));
      chk("ovr_err", 32'(o_err), 32'(cyc >= 2 * OVR_INT));
      chk("ovr_quiet", 32'({o_gnt, o_done, o_wr, o_rd, o_ba, o_row, o_col, o_len}), 32'd0);
    end

    // Single write with fixed fields
    do_reset();
    req = 2'b01; req_wr = 2'b01; req_ba = 4'h2; req_row = 26'h0123;
    req_col = 20'h010; req_len = 8'h05;
    do_txn(2, 22, 1'b1, 1'b0);
    chk("wr_len_kept", 32'(len_o), 32'd5);

    // Randomized traffic
    do_reset();
    for (int t = 0; t < 40; t++) begin
      req     = 2'($urandom_range(1, 3));
      req_wr  = 2'($urandom);
      req_ba  = 4'($urandom);
      req_row = 26'($urandom);
      req_col = 20'($urandom);
      req_len = 8'($urandom);
      do_txn(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("rand_no_err", 32'(err), 32'd0);

    // Contention, both reading, REQ held throughout
    do_reset();
    req = 2'b11; req_wr = 2'b00; req_ba = 4'hE; req_row = 26'h3FF_F0F0;
    req_col = 20'hABCDE; req_len = 8'hA5;
    for (int i = 0; i < 4; i++) do_txn(1 + i, 2, 1'b0, 1'b0);
    req = 2'b00;

    // Issue timeout with BUSY never rising
    do_reset();
    req = 2'b01; req_wr = 2'b01; req_len = 8'h07; req_ba = 4'h1;
    tick();
    chk("tmo_gnt", 32'(gnt), 32'd1);
    chk("tmo_err_pre", 32'(err), 32'd0);
    req = 2'b00;
    hold = wr_o ? 1 : 0;
    while (wr_o && hold < 300) begin
      tick();
      if (wr_o) hold++;
      chk("tmo_no_done", 32'(done), 32'd0);
    end
    chk("tmo_len", 32'(hold), 32'd255);
    chk("tmo_err", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tmo_after", 32'({done, gnt, wr_o, rd_o}), 32'd0);
    end
    req = 2'b10; req_wr = 2'b10;
    do_txn(1, 2, 1'b1, 1'b0);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset in the middle of ISSUE
    do_reset();
    req = 2'b01; req_wr = 2'b01; req_ba = 4'h3; req_row = 26'h1ABC;
    req_col = 20'h155; req_len = 8'h09;
    tick();
    chk("mid_wr", 32'(wr_o), 32'd1);
    req = 2'b00;
    tick();
    chk("mid_wr_hold", 32'(wr_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 32'({gnt, done, wr_o, rd_o, rreq, err}), 32'd0);
    chk("mid_rst_fields", 32'({ba_o, row_o, col_o, len_o}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0; last_m = 1;
    req = 2'b11; req_wr = 2'b00;
    do_txn(1, 2, 1'b1, 1'b0);

    // Refresh becomes pending during WAIT_DONE and wins over a held request
    do_reset();
    while (cyc < 770) tick();
    chk("ref_none_yet", 32'(rreq), 32'd0);
    req = 2'b01; req_wr = 2'b00; req_ba = 4'h1; req_row = 26'h0055; req_col = 20'h033;
    do_txn(1, 15, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ref_req", 32'(rreq), 32'd1);
      chk("ref_no_gnt", 32'(gnt), 32'd0);
    end
    rack = 1'b1;
    tick();
    chk("ref_cleared", 32'({rreq, gnt}), 32'd0);
    rack = 1'b0;
    do_txn(2, 2, 1'b1, 1'b0);
    chk("ref_no_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
